// File: rtl/mem_arb_pkg.sv
// Shared types and limits for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef logic       port_t;
  typedef logic [1:0] cnt_t;

  localparam port_t PORT0 = 1'b0;
  localparam port_t PORT1 = 1'b1;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 4;

  // Out-of-range latencies are pulled to the nearest legal value so the counter never wraps.
  function automatic int clamp_lat(input int lat);
    if (lat < MEM_LAT_MIN) begin
      return MEM_LAT_MIN;
    end else if (lat > MEM_LAT_MAX) begin
      return MEM_LAT_MAX;
    end else begin
      return lat;
    end
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational 2-way round-robin picker: on a tie the port that did not win last time wins.
module rr_pick
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_idx
);

  // Winner selection
  always_comb begin
    grant_valid = req0 | req1;
    if (req0 && req1) begin
      grant_idx = ~last_grant;
    end else if (req1) begin
      grant_idx = PORT1;
    end else begin
      grant_idx = PORT0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and sequencer for a single-port memory with fixed read latency.
// One transaction is in flight at a time; all outputs come straight from flops.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam cnt_t LAT_M1 = cnt_t'(clamp_lat(MEM_LAT) - 1);

  state_t            r_state;
  state_t            w_next_state;
  port_t             r_last_grant;
  port_t             r_cmd_win;
  logic              r_cmd_we;
  logic [ADDR_W-1:0] r_cmd_addr;
  logic [DATA_W-1:0] r_cmd_wdata;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  cnt_t              r_cnt;
  logic              r_mem_en;
  logic              r_mem_we;
  logic              r_ack0;
  logic              r_ack1;

  logic              w_grant_valid;
  port_t             w_grant_idx;
  logic              w_latch;
  logic              w_cap;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_mem_en_nxt;
  logic              w_mem_we_nxt;
  logic              w_ack0_nxt;
  logic              w_ack1_nxt;

  rr_pick u_pick (
    .req0        (req0),
    .req1        (req1),
    .last_grant  (r_last_grant),
    .grant_valid (w_grant_valid),
    .grant_idx   (w_grant_idx)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; requests are only looked at in IDLE
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_valid) begin
          w_next_state = ISSUE;
        end else begin
          w_next_state = IDLE;
        end
      end
      ISSUE: begin
        if (r_cmd_we) begin
          w_next_state = RESP;
        end else begin
          w_next_state = WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == 2'd0) begin
          w_next_state = RESP;
        end else begin
          w_next_state = WAIT;
        end
      end
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Output decode: next values for the registered strobes, acks and winner's command
  always_comb begin
    w_latch = (r_state == IDLE) && w_grant_valid;
    w_cap   = (r_state == WAIT) && (r_cnt == 2'd0);
    if (w_grant_idx == PORT1) begin
      w_sel_we    = we1;
      w_sel_addr  = addr1;
      w_sel_wdata = wdata1;
    end else begin
      w_sel_we    = we0;
      w_sel_addr  = addr0;
      w_sel_wdata = wdata0;
    end
    w_mem_en_nxt = w_latch;
    w_mem_we_nxt = w_latch & w_sel_we;
    w_ack0_nxt   = (w_next_state == RESP) && (r_cmd_win == PORT0);
    w_ack1_nxt   = (w_next_state == RESP) && (r_cmd_win == PORT1);
  end

  // Command, counter, read-data and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_grant <= PORT1;
      r_cmd_win    <= PORT0;
      r_cmd_we     <= 1'b0;
      r_cmd_addr   <= '0;
      r_cmd_wdata  <= '0;
      r_cnt        <= 2'd0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
    end else begin
      r_mem_en <= w_mem_en_nxt;
      r_mem_we <= w_mem_we_nxt;
      r_ack0   <= w_ack0_nxt;
      r_ack1   <= w_ack1_nxt;
      // The command registers double as the held memory address/data between accesses
      if (w_latch) begin
        r_cmd_win    <= w_grant_idx;
        r_cmd_we     <= w_sel_we;
        r_cmd_addr   <= w_sel_addr;
        r_cmd_wdata  <= w_sel_wdata;
        r_last_grant <= w_grant_idx;
      end
      if (r_state == ISSUE) begin
        r_cnt <= LAT_M1;
      end else if ((r_state == WAIT) && (r_cnt != 2'd0)) begin
        r_cnt <= r_cnt - 2'd1;
      end
      if (w_cap && (r_cmd_win == PORT0)) begin
        r_rdata0 <= mem_rdata;
      end
      if (w_cap && (r_cmd_win == PORT1)) begin
        r_rdata1 <= mem_rdata;
      end
    end
  end

  assign ack0      = r_ack0;
  assign ack1      = r_ack1;
  assign rdata0    = r_rdata0;
  assign rdata1    = r_rdata1;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_cmd_addr;
  assign mem_wdata = r_cmd_wdata;

endmodule
